reset_sequencer: RTL and testbench

//  Board-level reset controller that sits between the PLL and all downstream logic.
//  - Combines pll_locked, the reset push-button and a soft request into one restart decision.
//  - Releases NUM_STAGES reset domains in fixed order, with a programmable gap between each.
//  - Reports sequence completion and counts PLL lock losses.

---
 rtl/reset_sequencer_pkg.sv | 19 +
 rtl/reset_sequencer_btn_debounce.sv | 59 +++++
 rtl/reset_sequencer.sv | 138 +++++++++++++
 tb/tb_reset_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_sequencer_pkg.sv
// rtl/reset_sequencer_pkg.sv - shared states, widths and helpers for the reset sequencer
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_HOLD      = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } seq_state_t;

    localparam int LOCK_LOSS_W = 8;
    localparam logic [LOCK_LOSS_W-1:0] LOCK_LOSS_MAX = '1;

    // Bits needed to hold 0..value-1, never less than one bit
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/reset_sequencer_btn_debounce.sv
// rtl/reset_sequencer_btn_debounce.sv - push-button synchronizer, debouncer and press detector
module btn_debounce
    import reset_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic btn_db,
    output logic press
);

    localparam int CNT_W = clog2_min1(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_btn_s;
    logic             r_btn_db;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    // Two-flop synchronizer for the raw, asynchronous button
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_btn_s <= 1'b0;
        end else begin
            r_sync1 <= btn;
            r_btn_s <= r_sync1;
        end
    end

    // Accept a new level only after it has disagreed for a full stable window; flag new presses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_btn_db <= 1'b0;
            r_press  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_press <= 1'b0;
            if (r_btn_s != r_btn_db) begin
                if (r_cnt == CNT_LAST) begin
                    r_btn_db <= r_btn_s;
                    r_press  <= r_btn_s;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign btn_db = r_btn_db;
    assign press  = r_press;

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered multi-domain reset release with restart and lock-loss tracking
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int NUM_STAGES      = 3,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 64,
    parameter int STAGE_DELAY     = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pll_locked,
    input  logic                   btn,
    input  logic                   soft_req,
    output logic [NUM_STAGES-1:0]  stage_rst,
    output logic                   seq_done,
    output logic [LOCK_LOSS_W-1:0] lock_loss
);

    localparam int TMR_MAX = (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
    localparam int TMR_W   = clog2_min1(TMR_MAX);
    localparam int IDX_W   = clog2_min1(NUM_STAGES);
    localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] STAGE_LAST = TMR_W'(STAGE_DELAY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_STAGES - 1);

    logic                   r_lock_meta;
    logic                   r_lock_s;
    logic                   w_btn_db;
    logic                   w_press;
    logic                   w_lock_lost;
    logic                   w_restart;
    seq_state_t             r_state;
    logic [TMR_W-1:0]       r_timer;
    logic [IDX_W-1:0]       r_idx;
    logic [NUM_STAGES-1:0]  r_stage_rst;
    logic                   r_seq_done;
    logic [LOCK_LOSS_W-1:0] r_lock_loss;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk    (clk),
        .reset  (reset),
        .btn    (btn),
        .btn_db (w_btn_db),
        .press  (w_press)
    );

    // Two-flop synchronizer for the PLL lock indicator
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= pll_locked;
            r_lock_s    <= r_lock_meta;
        end
    end

    // Lock only matters once domains may be coming out of reset; a press always
    // coincides with a high debounced level, so the AND just documents that pairing.
    assign w_lock_lost = !r_lock_s && ((r_state == ST_RELEASE) || (r_state == ST_RUN));
    assign w_restart   = (w_press & w_btn_db) | soft_req | w_lock_lost;

    // Sequencer: hold, wait for lock, release domains in order, then run; restart wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_HOLD;
            r_timer     <= '0;
            r_idx       <= '0;
            r_stage_rst <= '1;
            r_seq_done  <= 1'b0;
        end else if (w_restart) begin
            r_state     <= ST_HOLD;
            r_timer     <= '0;
            r_idx       <= '0;
            r_stage_rst <= '1;
            r_seq_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (r_timer == HOLD_LAST) begin
                        r_state <= ST_WAIT_LOCK;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (r_lock_s) begin
                        r_state <= ST_RELEASE;
                        r_timer <= '0;
                        r_idx   <= '0;
                    end
                end
                ST_RELEASE: begin
                    if (r_timer == STAGE_LAST) begin
                        r_timer <= '0;
                        for (int k = 0; k < NUM_STAGES; k++) begin
                            if (r_idx == IDX_W'(k)) begin
                                r_stage_rst[k] <= 1'b0;
                            end
                        end
                        if (r_idx == IDX_LAST) begin
                            r_state    <= ST_RUN;
                            r_seq_done <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_RUN: begin
                    r_seq_done <= 1'b1;
                end
                default: begin
                    r_state <= ST_HOLD;
                end
            endcase
        end
    end

    // Saturating tally of lock drops seen while domains were releasing or running
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lock_loss <= '0;
        end else if (w_lock_lost && (r_lock_loss != LOCK_LOSS_MAX)) begin
            r_lock_loss <= r_lock_loss + 1'b1;
        end
    end

    assign stage_rst = r_stage_rst;
    assign seq_done  = r_seq_done;
    assign lock_loss = r_lock_loss;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - self-checking bench for reset_sequencer
module tb_reset_sequencer;

    localparam int NS   = 3;
    localparam int DEB  = 4;
    localparam int HOLD = 5;
    localparam int SD   = 8;

    logic          clk        = 1'b0;
    logic          reset      = 1'b0;
    logic          pll_locked = 1'b0;
    logic          btn        = 1'b0;
    logic          soft_req   = 1'b0;
    logic [NS-1:0] stage_rst;
    logic          seq_done;
    logic [7:0]    lock_loss;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: sequence described by the edge at which hold began and
    // the edge at which release began; stage k is low from release + SD*(k+1).
    int m_cyc        = 0;
    int m_hold_start = 0;
    int m_rel_start  = -1;
    int m_dbn_run    = 0;
    int m_ll         = 0;
    bit m_btn_d1, m_btn_s, m_db, m_press, m_lock_d1, m_lock_s;

    reset_sequencer #(
        .NUM_STAGES      (NS),
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .STAGE_DELAY     (SD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pll_locked (pll_locked),
        .btn        (btn),
        .soft_req   (soft_req),
        .stage_rst  (stage_rst),
        .seq_done   (seq_done),
        .lock_loss  (lock_loss)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    function automatic logic [NS-1:0] exp_stage();
        logic [NS-1:0] v;
        v = '1;
        for (int k = 0; k < NS; k++)
            if (m_rel_start >= 0 && m_cyc >= m_rel_start + SD * (k + 1)) v[k] = 1'b0;
        return v;
    endfunction

    function automatic logic exp_done();
        return (m_rel_start >= 0) && (m_cyc >= m_rel_start + SD * NS);
    endfunction

    function automatic void model_reset();
        m_hold_start = m_cyc;
        m_rel_start  = -1;
        m_dbn_run    = 0;
        m_ll         = 0;
        m_btn_d1 = 0; m_btn_s = 0; m_db = 0; m_press = 0;
        m_lock_d1 = 0; m_lock_s = 0;
    endfunction

    function automatic void model_edge();
        bit relrun, lost, restart, pre_btn_s, pre_db;
        m_cyc++;
        relrun  = (m_rel_start >= 0);
        lost    = relrun && !m_lock_s;
        restart = m_press || soft_req || lost;
        if (lost && m_ll < 255) m_ll++;
        if (restart) begin
            m_hold_start = m_cyc;
            m_rel_start  = -1;
        end else if (!relrun && (m_cyc - 1) >= m_hold_start + HOLD && m_lock_s) begin
            m_rel_start = m_cyc;
        end
        pre_btn_s = m_btn_s;
        pre_db    = m_db;
        m_press   = 0;
        if (pre_btn_s != pre_db) begin
            m_dbn_run++;
            if (m_dbn_run == DEB) begin
                m_db      = pre_btn_s;
                m_press   = pre_btn_s;
                m_dbn_run = 0;
            end
        end else begin
            m_dbn_run = 0;
        end
        m_btn_s  = m_btn_d1;
        m_btn_d1 = btn;
        m_lock_s  = m_lock_d1;
        m_lock_d1 = pll_locked;
    endfunction

    task automatic step();
        logic [NS-1:0] es;
        @(posedge clk);
        if (reset) model_edge();
        @(negedge clk);
        es = exp_stage();
        n_vec++;
        if (stage_rst !== es || seq_done !== exp_done() || lock_loss !== m_ll[7:0]) begin
            n_err++;
            $display("FAIL model cycle %0d: stage_rst=%b want %b, seq_done=%b want %b, lock_loss=%0d want %0d",
                     m_cyc, stage_rst, es, seq_done, exp_done(), lock_loss, m_ll);
        end
    endtask

    task automatic check_lit(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic wait_stage(input logic [NS-1:0] pat, input int budget, input string name);
        int n;
        n = 0;
        while (exp_stage() !== pat && n < budget) begin
            step();
            n++;
        end
        if (exp_stage() !== pat) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: timeout after %0d cycles waiting for %b", name, budget, pat);
        end
    endtask

    task automatic do_reset(input bit lock);
        #2;
        reset      = 1'b0;
        pll_locked = lock;
        btn        = 1'b0;
        soft_req   = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) step();
        reset = 1'b1;
    endtask

    initial begin
        int restarts;
        logic [NS-1:0] prev;
        int n;

        // 1. Power-up with lock present throughout
        do_reset(1'b1);
        for (int i = 1; i <= 30; i++) begin
            step();
            if (i == 13) check_lit("pwr_stage_e13", int'(stage_rst), 7);
            if (i == 14) check_lit("pwr_stage_e14", int'(stage_rst), 6);
            if (i == 21) check_lit("pwr_stage_e21", int'(stage_rst), 6);
            if (i == 22) check_lit("pwr_stage_e22", int'(stage_rst), 4);
            if (i == 29) check_lit("pwr_done_e29", int'(seq_done), 0);
            if (i == 30) begin
                check_lit("pwr_stage_e30", int'(stage_rst), 0);
                check_lit("pwr_done_e30", int'(seq_done), 1);
            end
        end

        // 2. Late lock
        do_reset(1'b0);
        for (int i = 1; i <= 51; i++) begin
            if (i == 41) pll_locked = 1'b1;
            step();
            if (i == 50) check_lit("late_stage_e50", int'(stage_rst), 7);
            if (i == 51) check_lit("late_stage_e51", int'(stage_rst), 6);
        end
        wait_stage('0, 40, "late_run");

        // 3. Bouncing button, then held: exactly one restart
        restarts = 0;
        prev = stage_rst;
        for (int i = 0; i < 80; i++) begin
            if (i < 20) btn = ~((i >> 1) & 1);
            else        btn = 1'b1;
            step();
            if (prev != '1 && stage_rst == '1) restarts++;
            prev = stage_rst;
        end
        check_lit("bounce_restarts", restarts, 1);
        wait_stage('0, 60, "bounce_rerun");
        check_lit("bounce_done", int'(seq_done), 1);
        btn = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check_lit("bounce_release_ignored", int'(seq_done), 1);

        // 4. Lock loss in RELEASE, then in RUN
        do_reset(1'b1);
        wait_stage(3'b110, 60, "ll_rel");
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        step();
        step();
        check_lit("ll1_stage", int'(stage_rst), 7);
        check_lit("ll1_count", int'(lock_loss), 1);
        wait_stage('0, 80, "ll_run");
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        step();
        step();
        check_lit("ll2_stage", int'(stage_rst), 7);
        check_lit("ll2_done", int'(seq_done), 0);
        check_lit("ll2_count", int'(lock_loss), 2);

        // 5. soft_req on the cycle the last stage would release
        n = 0;
        while (!(m_rel_start >= 0 && m_cyc + 1 == m_rel_start + SD * NS) && n < 100) begin
            step();
            n++;
        end
        check_lit("simul_reached", int'(m_rel_start >= 0 && m_cyc + 1 == m_rel_start + SD * NS), 1);
        soft_req = 1'b1;
        step();
        soft_req = 1'b0;
        check_lit("simul_stage", int'(stage_rst), 7);
        check_lit("simul_done", int'(seq_done), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            soft_req   = ($urandom_range(0, 99) == 0);
            pll_locked = ($urandom_range(0, 79) != 0);
            if ($urandom_range(0, 24) == 0) btn = ~btn;
            step();
        end
        soft_req   = 1'b0;
        pll_locked = 1'b1;
        btn        = 1'b0;
        for (int i = 0; i < 12; i++) step();

        // 6. Asynchronous reset mid-release
        wait_stage(3'b110, 80, "mid_rel");
        #2;
        reset = 1'b0;
        #1;
        check_lit("async_stage", int'(stage_rst), 7);
        check_lit("async_done", int'(seq_done), 0);
        check_lit("async_ll", int'(lock_loss), 0);
        model_reset();
        for (int i = 0; i < 3; i++) step();
        reset = 1'b1;

        // Lock-loss saturation
        for (int j = 0; j < 300; j++) begin
            n = 0;
            while (m_rel_start < 0 && n < 60) begin
                step();
                n++;
            end
            pll_locked = 1'b0;
            step();
            pll_locked = 1'b1;
            for (int i = 0; i < 3; i++) step();
        end
        check_lit("sat_count", int'(lock_loss), 255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
